// File: rtl/adder_serial_ctrl.sv
// Bit-serial adder controller: one half adder, two phases per bit.
// Optional final-carry output port enabled by `define ADDER_SERIAL_COUT_EN.

module adder_1bit_half #(
  parameter int IMPL_TYPE = 0
) (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  generate
    if (IMPL_TYPE == 1) begin : g_maj
      // Carry as majority with third input tied low; sum derived from it
      assign c = (a & b) | (a & 1'b0) | (b & 1'b0);
      assign s = (a | b) & ~c;
    end else begin : g_xor
      assign s = a ^ b;
      assign c = a & b;
    end
  endgenerate

endmodule

module adder_serial_ctrl #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ADDER_SERIAL_COUT_EN
  output logic             cout,
`endif
  output logic [WIDTH-1:0] sum
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    PH1,
    PH2,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             s1;
  logic             c1;
  logic             ha_a;
  logic             ha_b;
  logic             ha_s;
  logic             ha_c;

  // Half adder operand select: operand bits in PH1, partial sum and carry in PH2
  always_comb begin
    ha_a = s1;
    ha_b = carry;
    if (state == PH1) begin
      ha_a = a_reg[idx];
      ha_b = b_reg[idx];
    end
  end

  adder_1bit_half #(
    .IMPL_TYPE(IMPL_TYPE)
  ) u_ha (
    .a(ha_a),
    .b(ha_b),
    .s(ha_s),
    .c(ha_c)
  );

  // Control FSM with registered handshake outputs and datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      s1        <= 1'b0;
      c1        <= 1'b0;
`ifdef ADDER_SERIAL_COUT_EN
      cout      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            sum      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            in_ready <= 1'b0;
`ifdef ADDER_SERIAL_COUT_EN
            cout     <= 1'b0;
`endif
            state    <= PH1;
          end
        end
        PH1: begin
          s1    <= ha_s;
          c1    <= ha_c;
          state <= PH2;
        end
        PH2: begin
          sum[idx] <= ha_s;
          carry    <= c1 | ha_c;
          if (idx == LAST) begin
            out_valid <= 1'b1;
`ifdef ADDER_SERIAL_COUT_EN
            cout      <= c1 | ha_c;
`endif
            state     <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= PH1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Scoreboard bench for adder_serial_ctrl: WIDTH=8 with both adder forms
// in lockstep, plus a WIDTH=1 instance.

module tb_adder_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [7:0] sum0, sum1;
  logic       cout0, cout1;

  logic       in_valid_w;
  logic       out_ready_w;
  logic [0:0] a_w;
  logic [0:0] b_w;
  logic       in_ready_w;
  logic       out_valid_w;
  logic [0:0] sum_w;
  logic       cout_w;

  int ntests = 0;
  int nfail  = 0;
  logic [8:0] sb_q[$];

  always #5 clk = ~clk;

  adder_serial_ctrl #(.WIDTH(8), .IMPL_TYPE(0)) u_x (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
`ifdef ADDER_SERIAL_COUT_EN
    .cout(cout0),
`endif
    .sum(sum0)
  );

  adder_serial_ctrl #(.WIDTH(8), .IMPL_TYPE(1)) u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
`ifdef ADDER_SERIAL_COUT_EN
    .cout(cout1),
`endif
    .sum(sum1)
  );

  adder_serial_ctrl #(.WIDTH(1), .IMPL_TYPE(0)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
`ifdef ADDER_SERIAL_COUT_EN
    .cout(cout_w),
`endif
    .sum(sum_w)
  );

`ifndef ADDER_SERIAL_COUT_EN
  assign cout0  = 1'b0;
  assign cout1  = 1'b0;
  assign cout_w = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pair(input string tag, input logic [8:0] e);
    chk({tag, "_sum_x"}, 32'(sum0), 32'(e[7:0]));
    chk({tag, "_sum_m"}, 32'(sum1), 32'(e[7:0]));
`ifdef ADDER_SERIAL_COUT_EN
    chk({tag, "_cout_x"}, 32'(cout0), 32'(e[8]));
    chk({tag, "_cout_m"}, 32'(cout1), 32'(e[8]));
`endif
  endtask

  // Accept x+y; optionally offer junk operands mid-flight; hold DONE
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input bit noise, input int hold);
    int n;
    logic [8:0] e;
    logic [7:0] s_keep;
    chk("rdy_pre", 32'(in_ready0 & in_ready1), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    sb_q.push_back(9'(x) + 9'(y));
    @(posedge clk);
    #1;
    if (noise) begin
      a = ~x;
      b = x ^ y ^ 8'h5a;
    end else begin
      in_valid = 1'b0;
      a = 8'hxx;
      b = 8'hxx;
    end
    chk("rdy_busy", 32'(in_ready0 | in_ready1), 32'd0);
    n = 1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      if (n == 5) begin
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
      end
      if (out_valid0) break;
      n++;
    end
    chk("latency", 32'(n), 32'd16);
    chk("ov_m", 32'(out_valid1), 32'd1);
    e = sb_q.pop_front();
    check_pair("res", e);
    s_keep = sum0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_ov", 32'(out_valid0 & out_valid1), 32'd1);
      chk("hold_sum", 32'(sum0), 32'(s_keep));
      chk("hold_rdy", 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_rdy", 32'(in_ready0 & in_ready1), 32'd1);
    chk("idle_ov", 32'(out_valid0 | out_valid1), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    in_valid_w = 1'b0;
    out_ready_w = 1'b0;
    a_w = '0;
    b_w = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdy", 32'(in_ready0), 32'd1);
    chk("rst_ov", 32'(out_valid0), 32'd0);
    chk("rst_sum", 32'(sum0), 32'd0);
    chk("rst_cout", 32'(cout0), 32'd0);

    run8(8'h5a, 8'h3c, 1'b0, 0);
    run8(8'hff, 8'h01, 1'b0, 0);
    run8(8'h00, 8'h00, 1'b0, 0);
    run8(8'hc3, 8'h7e, 1'b0, 5);
    run8(8'h81, 8'h92, 1'b1, 1);
    for (int k = 0; k < 4; k++)
      run8(8'($urandom), 8'($urandom), k[0], 0);

    // Reset mid-operation drops the in-flight sum
    a = 8'h77;
    b = 8'h99;
    in_valid = 1'b1;
    sb_q.push_back(9'h110);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b0;
    sb_q.delete();
    chk("mrst_rdy", 32'(in_ready0 & in_ready1), 32'd1);
    chk("mrst_ov", 32'(out_valid0 | out_valid1), 32'd0);
    chk("mrst_sum", 32'(sum0 | sum1), 32'd0);
    chk("mrst_cout", 32'(cout0 | cout1), 32'd0);
    run8(8'h12, 8'h34, 1'b0, 0);

    // WIDTH=1 instance: 1+1 then 1+0
    for (int k = 0; k < 2; k++) begin
      a_w = 1'b1;
      b_w = 1'(k == 0);
      in_valid_w = 1'b1;
      @(posedge clk);
      #1;
      in_valid_w = 1'b0;
      n = 1;
      while (n < 20) begin
        @(posedge clk);
        #1;
        if (out_valid_w) break;
        n++;
      end
      chk("w1_lat", 32'(n), 32'd2);
      chk("w1_sum", 32'(sum_w), (k == 0) ? 32'd0 : 32'd1);
`ifdef ADDER_SERIAL_COUT_EN
      chk("w1_cout", 32'(cout_w), (k == 0) ? 32'd1 : 32'd0);
`endif
      out_ready_w = 1'b1;
      @(posedge clk);
      #1;
      out_ready_w = 1'b0;
      chk("w1_rdy", 32'(in_ready_w), 32'd1);
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
